// File: rtl/cross_cnt_event_rx.sv
// cross_cnt_event_rx: turns a synchronized wrapping count into valid/ready events; CROSS_CNT_GRAY_IN_EN selects gray-coded cnt_b
module cross_cnt_event_rx #(
  parameter int W        = 8,
  parameter int PW       = 10,
  parameter int MAX_STEP = 8
) (
  input  logic          clk_b,
  input  logic          rst_b,
  input  logic [W-1:0]  cnt_b,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [PW-1:0] pending,
  output logic          step_err,
  output logic          ovf,
  input  logic          clr_err
);
  localparam logic [W-1:0] MAX_D = W'(MAX_STEP);
  typedef enum logic {ALIGN, RUN} state_t;
  state_t state, state_nxt;
  logic [W-1:0] cnt_bin, last_cnt, delta_raw, delta;
  logic [PW:0] sum;
  logic run, big, acc, sat;
`ifdef CROSS_CNT_GRAY_IN_EN
  for (genvar g = 0; g < W; g++) begin : gray_dec
    assign cnt_bin[g] = ^cnt_b[W-1:g];
  end
`else
  assign cnt_bin = cnt_b;
`endif
  assign delta_raw = cnt_bin - last_cnt;
  assign big       = run && (delta_raw > MAX_D);
  assign delta     = (run && !big) ? delta_raw : '0;
  assign acc       = evt_valid & evt_ready;
  assign sum       = {1'b0, pending} + (PW+1)'(delta) - (PW+1)'(acc);
  assign sat       = sum[PW];
  // state register: ALIGN only for the first cycle after reset
  always_ff @(posedge clk_b)
    state <= rst_b ? ALIGN : state_nxt;
  // next state: ALIGN always moves to RUN, RUN is absorbing
  always_comb
    state_nxt = RUN;
  // outputs decoded from state and the pending register
  always_comb begin
    run       = (state == RUN);
    evt_valid = (pending != '0);
  end
  // count tracking, saturating pending queue and sticky error flags
  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      last_cnt <= '0;
      pending  <= '0;
      step_err <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      last_cnt <= cnt_bin;
      pending  <= sat ? '1 : sum[PW-1:0];
      step_err <= big | (step_err & ~clr_err);
      ovf      <= sat | (ovf & ~clr_err);
    end
  end
endmodule

// File: tb/tb_cross_cnt_event_rx.sv
// tb_cross_cnt_event_rx: directed and random stimulus checked against a behavioural event-queue model
module tb_cross_cnt_event_rx;
  logic       clk_b = 1'b0;
  logic       rst_b = 1'b1;
  logic [7:0] cnt_b = 8'h37;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [9:0] pending;
  logic       step_err;
  logic       ovf;
  logic       clr_err = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int m_pend = 0, m_last = 0, m_acc = 0;
  bit m_serr = 0, m_ovf = 0, m_align = 1, m_ok = 0;
  cross_cnt_event_rx #(.W(8), .PW(10), .MAX_STEP(8)) dut (
    .clk_b(clk_b), .rst_b(rst_b), .cnt_b(cnt_b), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .pending(pending), .step_err(step_err),
    .ovf(ovf), .clr_err(clr_err)
  );
  always #5 clk_b = ~clk_b;
  function automatic logic [7:0] enc(input int c);
    logic [7:0] b;
    b = c[7:0];
`ifdef CROSS_CNT_GRAY_IN_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction
  function automatic int dec(input logic [7:0] v);
    int b;
`ifdef CROSS_CNT_GRAY_IN_EN
    b = 0;
    for (int k = 0; k < 8; k++) b = b ^ (int'(v) >> k);
`else
    b = int'(v);
`endif
    return b;
  endfunction
  task automatic lit(input string n, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic drive(input int c, input bit r, input bit clr, input bit rst);
    @(negedge clk_b);
    cnt_b = enc(c);
    evt_ready = r;
    clr_err = clr;
    rst_b = rst;
  endtask
  // reference model: events are count advances, queued in a saturating counter
  always @(posedge clk_b) begin
    int b, d, s;
    bit a, se, oe;
    if (rst_b) begin
      m_pend = 0; m_last = 0; m_serr = 0; m_ovf = 0; m_align = 1; m_ok = 1;
    end else begin
      b = dec(cnt_b);
      d = (b - m_last + 256) % 256;
      a = (m_pend > 0) && evt_ready;
      se = 0;
      oe = 0;
      if (m_align) d = 0;
      else if (d > 8) begin d = 0; se = 1; end
      s = m_pend + d - (a ? 1 : 0);
      if (s > 1023) begin s = 1023; oe = 1; end
      if (a) m_acc++;
      m_pend = s;
      m_serr = se | (m_serr & !clr_err);
      m_ovf = oe | (m_ovf & !clr_err);
      m_last = b;
      m_align = 0;
    end
  end
  // every-cycle comparison of DUT against the model
  always @(negedge clk_b) begin
    if (m_ok) begin
      lit("pending", int'(pending), m_pend);
      lit("evt_valid", int'(evt_valid), (m_pend != 0) ? 1 : 0);
      lit("step_err", int'(step_err), int'(m_serr));
      lit("ovf", int'(ovf), int'(m_ovf));
    end
  end
  initial begin
    int c, a0;
    drive(8'h37, 0, 0, 1);
    drive(8'h37, 0, 0, 1);
    lit("rst_pending", int'(pending), 0);
    lit("rst_valid", int'(evt_valid), 0);
    lit("rst_step_err", int'(step_err), 0);
    lit("rst_ovf", int'(ovf), 0);
    for (int i = 0; i < 5; i++) drive(8'h37, 0, 0, 0);
    lit("align_pending", int'(pending), 0);
    lit("align_step_err", int'(step_err), 0);
    lit("model_align", m_pend, 0);
    drive(8'h10, 1, 0, 1);
    drive(8'h10, 1, 0, 0);
    a0 = m_acc;
    drive(8'h11, 1, 0, 0);
    drive(8'h12, 1, 0, 0);
    lit("inc_valid", int'(evt_valid), 1);
    lit("inc_pending", int'(pending), 1);
    drive(8'h12, 1, 0, 0);
    drive(8'h12, 1, 0, 0);
    lit("inc_drain", int'(pending), 0);
    lit("model_inc_acc", m_acc - a0, 2);
    drive(8'hFE, 0, 0, 1);
    drive(8'hFE, 0, 0, 0);
    drive(8'h03, 0, 0, 0);
    drive(8'h03, 0, 0, 0);
    lit("wrap_pending", int'(pending), 5);
    lit("wrap_step_err", int'(step_err), 0);
    lit("model_wrap", m_pend, 5);
    for (int i = 0; i < 5; i++) drive(8'h03, 1, 0, 0);
    lit("burst_last", int'(pending), 1);
    drive(8'h03, 1, 0, 0);
    lit("burst_empty", int'(evt_valid), 0);
    drive(8'h20, 0, 0, 1);
    drive(8'h20, 0, 0, 0);
    drive(8'h40, 0, 0, 0);
    drive(8'h41, 0, 0, 0);
    lit("jump_step_err", int'(step_err), 1);
    lit("jump_pending", int'(pending), 0);
    drive(8'h41, 0, 1, 0);
    lit("jump_next_pending", int'(pending), 1);
    drive(8'h41, 0, 0, 0);
    lit("clr_step_err", int'(step_err), 0);
    c = 8'h41;
    for (int i = 0; i < 130; i++) begin c = (c + 8) % 256; drive(c, 0, 0, 0); end
    drive(c, 0, 0, 0);
    lit("sat_pending", int'(pending), 1023);
    lit("sat_ovf", int'(ovf), 1);
    lit("model_sat", m_pend, 1023);
    c = (c + 8) % 256;
    drive(c, 0, 1, 0);
    drive(c, 0, 0, 0);
    lit("clr_vs_set_ovf", int'(ovf), 1);
    drive(c, 0, 1, 0);
    drive(c, 0, 0, 0);
    lit("clr_ovf", int'(ovf), 0);
    lit("sat_hold", int'(pending), 1023);
    drive(8'h50, 0, 0, 1);
    drive(8'h50, 0, 0, 0);
    drive(8'h53, 0, 0, 0);
    drive(8'h55, 1, 0, 0);
    lit("sim_before", int'(pending), 3);
    drive(8'h55, 0, 0, 0);
    lit("sim_after", int'(pending), 4);
    drive(8'h55, 0, 0, 1);
    drive(8'h60, 0, 0, 0);
    lit("midrst_pending", int'(pending), 0);
    drive(8'h60, 0, 0, 0);
    drive(8'h61, 0, 0, 0);
    lit("midrst_noreplay", int'(pending), 0);
    drive(8'h61, 0, 0, 0);
    lit("midrst_step", int'(pending), 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(2, 0, 0, 0);
    drive(3, 0, 0, 0);
    drive(3, 0, 0, 0);
    lit("seq3_pending", int'(pending), 3);
    c = 3;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      if ($urandom_range(0, 19) == 0) c = (c + $urandom_range(9, 200)) % 256;
      else c = (c + $urandom_range(0, 8)) % 256;
      r = ((i / 500) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      drive(c, r, $urandom_range(0, 15) == 0, $urandom_range(0, 399) == 0);
    end
    drive(c, 0, 0, 0);
    drive(c, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
